// File: rtl/spi_xip_pkg.sv
// spi_xip_pkg: shared constants, state encoding and sequencing helpers for the
// XIP sequencer (spi_xip_ctrl). Build option XIP_BYTE_SWAP_EN is consumed in the top.
package spi_xip_pkg;

    // SPI master register offsets
    localparam logic [4:0] OFF_RX0     = 5'h00;
    localparam logic [4:0] OFF_TX0     = 5'h00;
    localparam logic [4:0] OFF_TX1     = 5'h04;
    localparam logic [4:0] OFF_CTRL    = 5'h10;
    localparam logic [4:0] OFF_DIVIDER = 5'h14;
    localparam logic [4:0] OFF_SS      = 5'h18;

    // CTRL value that starts a 64-bit, auto-SS, TX-on-negedge transfer
    localparam logic [31:0] CTRL_XIP_GO    = 32'h0000_2540;
    localparam int          GO_BSY_BIT     = 8;
    localparam logic [7:0]  FLASH_CMD_READ = 8'h03;

    // Upstream address windows (paddr[31:28])
    localparam logic [3:0] WIN_SPI_REGS = 4'h1;
    localparam logic [3:0] WIN_FLASH    = 4'h3;

    typedef enum logic [3:0] {
        IDLE,
        W_TX1,
        W_DIV,
        W_SS,
        W_CTRL,
        POLL,
        R_RX0,
        W_SSOFF,
        RESP
    } xip_state_e;

    // One downstream register access
    typedef struct packed {
        logic        write;
        logic [4:0]  offset;
        logic [31:0] wdata;
    } apb_cmd_t;

    // Step through the XIP sequence; POLL repeats while the master reports busy
    function automatic xip_state_e seq_next(input xip_state_e s, input logic busy);
        case (s)
            IDLE:    seq_next = W_TX1;
            W_TX1:   seq_next = W_DIV;
            W_DIV:   seq_next = W_SS;
            W_SS:    seq_next = W_CTRL;
            W_CTRL:  seq_next = POLL;
            POLL:    seq_next = busy ? POLL : R_RX0;
            R_RX0:   seq_next = W_SSOFF;
            W_SSOFF: seq_next = RESP;
            default: seq_next = IDLE;
        endcase
    endfunction

    // The register access performed while in a given sequence state
    function automatic apb_cmd_t seq_cmd(input xip_state_e s, input logic [21:0] word_addr,
                                         input logic [31:0] divider, input logic [31:0] ss_mask);
        seq_cmd = '0;
        case (s)
            W_TX1:   seq_cmd = '{write: 1'b1, offset: OFF_TX1,     wdata: {FLASH_CMD_READ, word_addr, 2'b00}};
            W_DIV:   seq_cmd = '{write: 1'b1, offset: OFF_DIVIDER, wdata: divider};
            W_SS:    seq_cmd = '{write: 1'b1, offset: OFF_SS,      wdata: ss_mask};
            W_CTRL:  seq_cmd = '{write: 1'b1, offset: OFF_CTRL,    wdata: CTRL_XIP_GO};
            POLL:    seq_cmd = '{write: 1'b0, offset: OFF_CTRL,    wdata: 32'd0};
            R_RX0:   seq_cmd = '{write: 1'b0, offset: OFF_RX0,     wdata: 32'd0};
            W_SSOFF: seq_cmd = '{write: 1'b1, offset: OFF_SS,      wdata: 32'd0};
            default: seq_cmd = '0;
        endcase
    endfunction

    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        byte_swap = {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_xip_if.sv
// spi_xip_apb_if: APB3/4 bus bundle used on both sides of spi_xip_ctrl.
// Handshake: an access is a setup cycle (psel=1, penable=0) followed by one or
// more access cycles (psel=1, penable=1); it completes in the access cycle in
// which the slave drives pready=1, and prdata/pslverr are valid only then.
interface spi_xip_apb_if #(parameter int AW = 32);
    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [2:0]    pprot;
    logic [31:0]   pwdata;
    logic [3:0]    pstrb;
    logic          pready;
    logic          pslverr;
    logic [31:0]   prdata;

    modport master (
        output paddr, psel, penable, pwrite, pprot, pwdata, pstrb,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pprot, pwdata, pstrb,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/spi_xip_apb_req.sv
// spi_xip_apb_req: single-access APB master. A start pulse loads a command and
// the setup phase appears on the next cycle; done/rdata/err are presented in
// the completing access cycle.
module spi_xip_apb_req
    import spi_xip_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_start,
    input  apb_cmd_t    i_cmd,
    output logic        o_psel,
    output logic        o_penable,
    output logic        o_pwrite,
    output logic [4:0]  o_paddr,
    output logic [31:0] o_pwdata,
    output logic [3:0]  o_pstrb,
    input  logic        i_pready,
    input  logic        i_pslverr,
    input  logic [31:0] i_prdata,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_err
);
    logic        r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [4:0]  r_paddr;
    logic [31:0] r_pwdata;
    logic [3:0]  r_pstrb;
    logic        w_done;

    assign w_done = r_psel && r_penable && i_pready;

    // Setup -> access -> idle; a start in the completing cycle chains the next access
    always_ff @(posedge clock) begin
        if (reset) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
        end else if (i_start) begin
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_pwrite  <= i_cmd.write;
            r_paddr   <= i_cmd.offset;
            r_pwdata  <= i_cmd.write ? i_cmd.wdata : 32'd0;
            r_pstrb   <= i_cmd.write ? 4'hF : 4'h0;
        end else if (r_psel && !r_penable) begin
            r_penable <= 1'b1;
        end else if (w_done) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
        end
    end

    assign o_psel    = r_psel;
    assign o_penable = r_penable;
    assign o_pwrite  = r_pwrite;
    assign o_paddr   = r_paddr;
    assign o_pwdata  = r_pwdata;
    assign o_pstrb   = r_pstrb;
    assign o_done    = w_done;
    assign o_rdata   = w_done ? i_prdata : 32'd0;
    assign o_err     = w_done && i_pslverr;
endmodule

// File: rtl/spi_xip_ctrl.sv
// spi_xip_ctrl: execute-in-place sequencer between the APB crossbar and the SPI
// master. Window 0x1 passes through, window 0x3 reads become a flash READ
// transaction, everything else errors. Build option: XIP_BYTE_SWAP_EN returns
// the fetched flash word byte-reversed (little-endian word order).
module spi_xip_ctrl
    import spi_xip_pkg::*;
#(
    parameter int          flash_ss_bit = 0,
    parameter logic [31:0] xip_divider  = 32'd0
)(
    input  logic          clock,
    input  logic          reset,
    spi_xip_apb_if.slave  in_apb,
    spi_xip_apb_if.master out_apb,
    output xip_state_e    o_dbg_state
);
    localparam logic [31:0] SS_MASK = 32'd1 << flash_ss_bit;

    xip_state_e  r_state;
    logic [21:0] r_addr;
    logic        r_err;
    logic [31:0] r_rx;

    logic [3:0]  w_window;
    logic        w_pass_sel;
    logic        w_xip_rd_setup;
    logic        w_err_access;
    logic        w_start;
    xip_state_e  w_cmd_state;
    apb_cmd_t    w_cmd;
    logic [21:0] w_cmd_addr;
    logic        w_req_psel;
    logic        w_req_penable;
    logic        w_req_pwrite;
    logic [4:0]  w_req_paddr;
    logic [31:0] w_req_pwdata;
    logic [3:0]  w_req_pstrb;
    logic        w_req_done;
    logic [31:0] w_req_rdata;
    logic        w_req_err;
    logic [31:0] w_rx_out;
    logic        w_unused_addr;

    // Flash addresses alias within 16 MiB and are word aligned
    assign w_unused_addr = &{1'b0, in_apb.paddr[27:24], in_apb.paddr[1:0]};

    assign w_window       = in_apb.paddr[31:28];
    assign w_pass_sel     = in_apb.psel && (w_window == WIN_SPI_REGS);
    assign w_xip_rd_setup = in_apb.psel && !in_apb.penable && (w_window == WIN_FLASH) && !in_apb.pwrite;
    assign w_err_access   = in_apb.psel && in_apb.penable && !w_pass_sel &&
                            !((w_window == WIN_FLASH) && !in_apb.pwrite);

    // The next access is launched from IDLE on the latch cycle, or chained on
    // completion of the current one (W_SSOFF completes into RESP, no access)
    assign w_start     = ((r_state == IDLE) && w_xip_rd_setup) ||
                         (w_req_done && (r_state inside {W_TX1, W_DIV, W_SS, W_CTRL, POLL, R_RX0}));
    assign w_cmd_state = seq_next(r_state, w_req_rdata[GO_BSY_BIT]);
    assign w_cmd_addr  = (r_state == IDLE) ? in_apb.paddr[23:2] : r_addr;
    assign w_cmd       = seq_cmd(w_cmd_state, w_cmd_addr, xip_divider, SS_MASK);

    spi_xip_apb_req u_req (
        .clock     (clock),
        .reset     (reset),
        .i_start   (w_start),
        .i_cmd     (w_cmd),
        .o_psel    (w_req_psel),
        .o_penable (w_req_penable),
        .o_pwrite  (w_req_pwrite),
        .o_paddr   (w_req_paddr),
        .o_pwdata  (w_req_pwdata),
        .o_pstrb   (w_req_pstrb),
        .i_pready  (out_apb.pready),
        .i_pslverr (out_apb.pslverr),
        .i_prdata  (out_apb.prdata),
        .o_done    (w_req_done),
        .o_rdata   (w_req_rdata),
        .o_err     (w_req_err)
    );

    // Sequencer: latch the word address, walk the register program, collect errors
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_err   <= 1'b0;
            r_rx    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xip_rd_setup) begin
                        r_addr  <= in_apb.paddr[23:2];
                        r_err   <= 1'b0;
                        r_state <= W_TX1;
                    end
                end
                RESP: r_state <= IDLE;
                default: begin
                    if (w_req_done) begin
                        r_err <= r_err | w_req_err;
                        if (r_state == R_RX0) r_rx <= w_req_rdata;
                        r_state <= w_cmd_state;
                    end
                end
            endcase
        end
    end

`ifdef XIP_BYTE_SWAP_EN
    assign w_rx_out = byte_swap(r_rx);
`else
    assign w_rx_out = r_rx;
`endif

    // Bus steering: passthrough and error replies in IDLE, sequencer otherwise
    always_comb begin
        out_apb.psel    = w_req_psel;
        out_apb.penable = w_req_penable;
        out_apb.pwrite  = w_req_pwrite;
        out_apb.paddr   = w_req_paddr;
        out_apb.pwdata  = w_req_pwdata;
        out_apb.pstrb   = w_req_pstrb;
        out_apb.pprot   = 3'b000;
        in_apb.pready   = 1'b0;
        in_apb.pslverr  = 1'b0;
        in_apb.prdata   = 32'd0;
        if (r_state == IDLE) begin
            if (w_pass_sel) begin
                out_apb.psel    = 1'b1;
                out_apb.penable = in_apb.penable;
                out_apb.pwrite  = in_apb.pwrite;
                out_apb.paddr   = in_apb.paddr[4:0];
                out_apb.pwdata  = in_apb.pwdata;
                out_apb.pstrb   = in_apb.pstrb;
                out_apb.pprot   = in_apb.pprot;
                in_apb.pready   = out_apb.pready;
                in_apb.pslverr  = out_apb.pslverr;
                in_apb.prdata   = out_apb.prdata;
            end else if (w_err_access) begin
                in_apb.pready  = 1'b1;
                in_apb.pslverr = 1'b1;
            end
        end else if (r_state == RESP) begin
            in_apb.pready  = 1'b1;
            in_apb.pslverr = r_err;
            in_apb.prdata  = w_rx_out;
        end
    end

    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_spi_xip_ctrl.sv
// tb_spi_xip_ctrl: randomized bench for spi_xip_ctrl with a behavioural SPI
// master/flash model, expected-response queues and decoupled monitors.
module tb_spi_xip_ctrl;
    import spi_xip_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    spi_xip_apb_if #(.AW(32)) in_apb ();
    spi_xip_apb_if #(.AW(5))  out_apb ();
    xip_state_e dbg_state;

    spi_xip_ctrl #(.flash_ss_bit(0), .xip_divider(32'd0)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_apb      (in_apb),
        .out_apb     (out_apb),
        .o_dbg_state (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    // downstream record: {write, offset[4:0], wdata[31:0], strb[3:0]}
    logic [41:0] exp_dn_q[$];
    // upstream record: {check_data, slverr, prdata[31:0]}
    logic [33:0] exp_up_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- flash / SPI master reference ----------------
    logic [7:0] flash[int];

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        if (flash.exists(int'(a))) return flash[int'(a)];
        return 8'(a * 37 + (a >> 8) * 11 + 24'h5A);
    endfunction

    // Flash is read MSB first: byte at the lowest address lands in bits [31:24]
    function automatic logic [31:0] flash_word(input logic [23:0] a);
        logic [23:0] b;
        b = {a[23:2], 2'b00};
        return {flash_byte(b), flash_byte(b + 24'd1), flash_byte(b + 24'd2), flash_byte(b + 24'd3)};
    endfunction

    function automatic logic [31:0] xip_data(input logic [31:0] w);
`ifdef XIP_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    logic [31:0] s_tx1, s_div, s_ss, s_ctrl, s_rx;
    int          s_busy_left = 0;
    int          s_waits_left = 0;
    int          cfg_busy_polls = 0;
    int          cfg_wait_min = 0;
    int          cfg_wait_max = 0;
    bit          cfg_err_armed = 0;
    logic [4:0]  cfg_err_off = 5'h00;

    task automatic slave_access();
        logic [4:0] off;
        off = out_apb.paddr;
        if (cfg_err_armed && off == cfg_err_off) begin
            out_apb.pslverr = 1'b1;
            cfg_err_armed = 0;
        end
        if (out_apb.pwrite) begin
            case (off)
                5'h04: s_tx1 = out_apb.pwdata;
                5'h14: s_div = out_apb.pwdata;
                5'h18: s_ss  = out_apb.pwdata;
                5'h10: begin
                    s_ctrl = out_apb.pwdata;
                    if (out_apb.pwdata[8]) begin
                        s_rx = flash_word(s_tx1[23:0]);
                        s_busy_left = cfg_busy_polls;
                    end
                end
                default: ;
            endcase
        end else begin
            case (off)
                5'h00: out_apb.prdata = s_rx;
                5'h04: out_apb.prdata = s_tx1;
                5'h14: out_apb.prdata = s_div;
                5'h18: out_apb.prdata = s_ss;
                5'h10: begin
                    out_apb.prdata = (s_ctrl & ~32'h100) | ((s_busy_left > 0) ? 32'h100 : 32'h0);
                    if (s_busy_left > 0) s_busy_left--;
                end
                default: out_apb.prdata = 32'd0;
            endcase
        end
    endtask

    // SPI master model, evaluated after the DUT and the upstream driver settle
    initial begin
        out_apb.pready = 1'b0;
        out_apb.pslverr = 1'b0;
        out_apb.prdata = 32'd0;
        s_tx1 = 0; s_div = 0; s_ss = 0; s_ctrl = 0; s_rx = 0;
        forever begin
            @(posedge clock);
            #2;
            out_apb.pready = 1'b0;
            out_apb.pslverr = 1'b0;
            out_apb.prdata = 32'd0;
            if (reset) begin
                s_busy_left = 0;
                s_ss = 0;
                s_ctrl = 0;
                s_waits_left = 0;
            end else if (out_apb.psel && !out_apb.penable) begin
                s_waits_left = $urandom_range(cfg_wait_max, cfg_wait_min);
            end else if (out_apb.psel && out_apb.penable) begin
                if (s_waits_left > 0) s_waits_left--;
                else begin
                    out_apb.pready = 1'b1;
                    slave_access();
                end
            end
        end
    end

    // ---------------- monitors (scoreboard side) ----------------
    always @(negedge clock) begin
        if (!reset && out_apb.psel && out_apb.penable && out_apb.pready) begin
            if (exp_dn_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL dn_unexpected: access wr=%0d off=0x%0h wdata=0x%0h, expected no access",
                         out_apb.pwrite, out_apb.paddr, out_apb.pwdata);
            end else begin
                logic [41:0] e;
                e = exp_dn_q.pop_front();
                check("dn_write", 64'(out_apb.pwrite), 64'(e[41]));
                check("dn_offset", 64'(out_apb.paddr), 64'(e[40:36]));
                check("dn_strb", 64'(out_apb.pstrb), 64'(e[3:0]));
                if (e[41]) check("dn_wdata", 64'(out_apb.pwdata), 64'(e[35:4]));
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && in_apb.psel && in_apb.penable && in_apb.pready) begin
            if (exp_up_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL up_unexpected: response prdata=0x%0h, expected none", in_apb.prdata);
            end else begin
                logic [33:0] e;
                e = exp_up_q.pop_front();
                check("up_slverr", 64'(in_apb.pslverr), 64'(e[32]));
                if (e[33]) check("up_prdata", 64'(in_apb.prdata), 64'(e[31:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                            input logic [3:0] strb, output int cycles);
        bit got;
        @(posedge clock);
        #1;
        in_apb.paddr = addr;
        in_apb.pwrite = wr;
        in_apb.pwdata = wr ? wdata : 32'd0;
        in_apb.pstrb = wr ? strb : 4'h0;
        in_apb.pprot = 3'b010;
        in_apb.psel = 1'b1;
        in_apb.penable = 1'b0;
        cycles = 1;
        @(posedge clock);
        #1;
        in_apb.penable = 1'b1;
        got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clock);
            cycles++;
            if (in_apb.pready) got = 1;
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL xfer_timeout: no pready for addr 0x%0h within 2000 cycles", addr);
        end
        @(posedge clock);
        #1;
        in_apb.psel = 1'b0;
        in_apb.penable = 1'b0;
        in_apb.pwrite = 1'b0;
    endtask

    task automatic push_xip_program(input logic [31:0] addr, input int polls);
        exp_dn_q.push_back({1'b1, 5'h04, {8'h03, addr[23:2], 2'b00}, 4'hF});
        exp_dn_q.push_back({1'b1, 5'h14, 32'd0, 4'hF});
        exp_dn_q.push_back({1'b1, 5'h18, 32'h1, 4'hF});
        exp_dn_q.push_back({1'b1, 5'h10, 32'h2540, 4'hF});
        for (int p = 0; p <= polls; p++) exp_dn_q.push_back({1'b0, 5'h10, 32'd0, 4'h0});
        exp_dn_q.push_back({1'b0, 5'h00, 32'd0, 4'h0});
        exp_dn_q.push_back({1'b1, 5'h18, 32'd0, 4'hF});
    endtask

    task automatic xip_read(input logic [31:0] addr, input int polls, input bit err_div, input int wmax);
        int cyc;
        cfg_busy_polls = polls;
        cfg_wait_min = 0;
        cfg_wait_max = wmax;
        if (err_div) begin
            cfg_err_armed = 1;
            cfg_err_off = 5'h14;
        end
        push_xip_program(addr, polls);
        exp_up_q.push_back({1'b1, err_div, xip_data(flash_word(addr[23:0]))});
        apb_xfer(addr, 1'b0, 32'd0, 4'h0, cyc);
        // setup/latch cycle + 2 per access (7 + polls) + RESP
        if (wmax == 0) check("xip_latency", 64'(cyc), 64'(16 + 2 * polls));
    endtask

    task automatic err_access(input logic [31:0] addr, input logic wr);
        int cyc;
        exp_up_q.push_back({1'b0, 1'b1, 32'd0});
        apb_xfer(addr, wr, $urandom, 4'hF, cyc);
        check("err_latency", 64'(cyc), 64'd2);
    endtask

    task automatic pt_write_read(input logic [4:0] off, input logic [31:0] d, input logic [3:0] strb, input int wmax);
        int cyc;
        cfg_wait_min = 0;
        cfg_wait_max = wmax;
        exp_dn_q.push_back({1'b1, off, d, strb});
        exp_up_q.push_back({1'b0, 1'b0, 32'd0});
        apb_xfer({4'h1, 23'($urandom), off}, 1'b1, d, strb, cyc);
        exp_dn_q.push_back({1'b0, off, 32'd0, 4'h0});
        exp_up_q.push_back({1'b1, 1'b0, d});
        apb_xfer({4'h1, 23'($urandom), off}, 1'b0, 32'd0, 4'h0, cyc);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        bit got;
        in_apb.paddr = 0; in_apb.psel = 0; in_apb.penable = 0; in_apb.pwrite = 0;
        in_apb.pprot = 0; in_apb.pwdata = 0; in_apb.pstrb = 0;
        flash[32'h104] = 8'h11;
        flash[32'h105] = 8'h22;
        flash[32'h106] = 8'h33;
        flash[32'h107] = 8'h44;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_out_psel", 64'(out_apb.psel), 64'd0);
        check("rst_out_penable", 64'(out_apb.penable), 64'd0);
        check("rst_out_pwrite", 64'(out_apb.pwrite), 64'd0);
        check("rst_out_paddr", 64'(out_apb.paddr), 64'd0);
        check("rst_out_pwdata", 64'(out_apb.pwdata), 64'd0);
        check("rst_out_pstrb", 64'(out_apb.pstrb), 64'd0);
        check("rst_in_pready", 64'(in_apb.pready), 64'd0);
        check("rst_in_pslverr", 64'(in_apb.pslverr), 64'd0);
        check("rst_in_prdata", 64'(in_apb.prdata), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        @(posedge clock);
        #1 reset = 1'b0;

        // passthrough write with two wait states
        cfg_wait_min = 2;
        cfg_wait_max = 2;
        exp_dn_q.push_back({1'b1, 5'h14, 32'h5, 4'hF});
        exp_up_q.push_back({1'b0, 1'b0, 32'd0});
        apb_xfer(32'h1000_1014, 1'b1, 32'h5, 4'hF, cyc);
        check("pt_latency", 64'(cyc), 64'd4);
        exp_dn_q.push_back({1'b0, 5'h14, 32'd0, 4'h0});
        exp_up_q.push_back({1'b1, 1'b0, 32'h5});
        apb_xfer(32'h1000_0014, 1'b0, 32'd0, 4'h0, cyc);

        // XIP reads: directed word, then a busy POLL loop
        xip_read(32'h3000_0104, 0, 0, 0);
        xip_read(32'h3000_0104, 3, 0, 0);

        // XIP write and an unmapped window
        err_access(32'h3000_0000, 1'b1);
        err_access(32'h2000_0000, 1'b0);

        // error on the DIVIDER write, aliased address
        xip_read(32'h3F00_0107, 1, 1, 0);

        // reset while the sequencer is polling
        cfg_busy_polls = 20;
        cfg_wait_min = 0;
        cfg_wait_max = 0;
        push_xip_program(32'h3000_0200, 20);
        @(posedge clock);
        #1;
        in_apb.paddr = 32'h3000_0200; in_apb.pwrite = 0; in_apb.psel = 1; in_apb.penable = 0;
        @(posedge clock);
        #1 in_apb.penable = 1;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clock);
            if (out_apb.psel && !out_apb.penable && !out_apb.pwrite && out_apb.paddr == 5'h10) got = 1;
        end
        check("poll_reached", 64'(got), 64'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        in_apb.psel = 0;
        in_apb.penable = 0;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("mid_rst_out_psel", 64'(out_apb.psel), 64'd0);
        check("mid_rst_out_penable", 64'(out_apb.penable), 64'd0);
        check("mid_rst_in_pready", 64'(in_apb.pready), 64'd0);
        check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
        exp_dn_q.delete();
        exp_up_q.delete();
        xip_read(32'h3000_0000, 0, 0, 0);

        // randomized mix
        for (int it = 0; it < 40; it++) begin
            int kind;
            kind = $urandom_range(3, 0);
            case (kind)
                0: xip_read({4'h3, 28'($urandom)}, $urandom_range(3, 0), ($urandom_range(3, 0) == 0), $urandom_range(1, 0) * 2);
                1: pt_write_read(($urandom_range(1, 0) == 0) ? 5'h04 : 5'h14, $urandom, 4'($urandom_range(15, 1)), $urandom_range(2, 0));
                2: begin
                    logic [3:0] nib;
                    nib = 4'($urandom_range(15, 0));
                    while (nib == 4'h1 || nib == 4'h3) nib = 4'($urandom_range(15, 0));
                    err_access({nib, 28'($urandom)}, 1'($urandom_range(1, 0)));
                end
                default: err_access({4'h3, 28'($urandom)}, 1'b1);
            endcase
        end

        repeat (5) @(posedge clock);
        check("dn_queue_drained", 64'(exp_dn_q.size()), 64'd0);
        check("up_queue_drained", 64'(exp_up_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // global time limit
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
